// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment patterns {a,b,c,d,e,f,g,dp}, BCD decode and reader FSM states.
package seg_pkg;

   localparam logic [7:0] SEG_0 = 8'hFC;
   localparam logic [7:0] SEG_1 = 8'h60;
   localparam logic [7:0] SEG_2 = 8'hDA;
   localparam logic [7:0] SEG_3 = 8'hF2;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'hB6;
   localparam logic [7:0] SEG_6 = 8'hBE;
   localparam logic [7:0] SEG_7 = 8'hE0;
   localparam logic [7:0] SEG_8 = 8'hFE;
   localparam logic [7:0] SEG_9 = 8'hF6;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_e;

   // Returns {valid, bcd}; the dp segment is not part of the pattern.
   function automatic logic [4:0] seg_to_bcd(input logic [6:0] pat);
      logic [4:0] r;
      r = {1'b0, BCD_INVALID};
      case (pat)
         SEG_0[7:1]: r = {1'b1, 4'd0};
         SEG_1[7:1]: r = {1'b1, 4'd1};
         SEG_2[7:1]: r = {1'b1, 4'd2};
         SEG_3[7:1]: r = {1'b1, 4'd3};
         SEG_4[7:1]: r = {1'b1, 4'd4};
         SEG_5[7:1]: r = {1'b1, 4'd5};
         SEG_6[7:1]: r = {1'b1, 4'd6};
         SEG_7[7:1]: r = {1'b1, 4'd7};
         SEG_8[7:1]: r = {1'b1, 4'd8};
         SEG_9[7:1]: r = {1'b1, 4'd9};
         default:    r = {1'b0, BCD_INVALID};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational decode of segments a..g into a BCD digit with a validity flag.
module seg_encode
   import seg_pkg::*;
(
   input  logic [6:0] seg_bits,
   output logic       valid_c,
   output logic [3:0] bcd_c
);

   assign {valid_c, bcd_c} = seg_to_bcd(seg_bits);

endmodule

// File: rtl/seg_scan_reader.sv
// Reader for a multiplexed 7-segment bus: debounces each digit slot, decodes it and
// publishes a complete frame once every slot has been captured.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int unsigned NDIG       = 4,
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          seg,
   input  logic [NDIG-1:0]     an,
   output logic [4*NDIG-1:0]   digits,
   output logic [NDIG-1:0]     dp_flags,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                stale
);

   localparam int unsigned SCNT_W = $clog2(STABLE_CYC + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned SMP_W  = 8 + NDIG;

   scan_state_e         state_q, state_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic [SMP_W-1:0]    prev_q, prev_d;
   logic [4*NDIG-1:0]   work_q, work_d;
   logic [NDIG-1:0]     wdp_q, wdp_d;
   logic [NDIG-1:0]     seen_q, seen_d;
   logic                err_acc_q, err_acc_d;
   logic                pub_q, pub_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [4*NDIG-1:0]   digits_q, digits_d;
   logic [NDIG-1:0]     dp_flags_q, dp_flags_d;
   logic                frame_valid_q, frame_valid_d;
   logic                frame_err_q, frame_err_d;
   logic                stale_q, stale_d;

   logic                legal, same, capture, enc_valid;
   logic [3:0]          enc_bcd;
   logic [SMP_W-1:0]    sample;
   scan_state_e         st_restart;
   logic [SCNT_W-1:0]   scnt_restart;
   logic [NDIG-1:0]     seen_base;
   logic                err_base;

   seg_encode u_encode (
      .seg_bits (seg[7:1]),
      .valid_c  (enc_valid),
      .bcd_c    (enc_bcd)
   );

   assign sample       = {seg, an};
   assign legal        = (an != '0) && ((an & (an - NDIG'(1))) == '0);
   assign same         = (sample == prev_q);
   assign st_restart   = legal ? ST_SETTLE : ST_WAIT;
   assign scnt_restart = legal ? SCNT_W'(1) : '0;

   // Stability FSM: a legal sample restarts the count whenever it differs from the previous one.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      capture = 1'b0;
      prev_d  = sample;
      case (state_q)
         ST_SETTLE: begin
            if (legal && same) begin
               if (scnt_q == SCNT_W'(STABLE_CYC - 1)) begin
                  capture = 1'b1;
                  state_d = ST_HELD;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end else begin
               state_d = st_restart;
               scnt_d  = scnt_restart;
            end
         end
         ST_HELD: begin
            if (!same) begin
               state_d = st_restart;
               scnt_d  = scnt_restart;
            end
         end
         default: begin
            state_d = st_restart;
            scnt_d  = scnt_restart;
         end
      endcase
   end

   // Frame assembly; a capture on the publish edge already belongs to the next frame.
   always_comb begin
      seen_base = pub_q ? '0 : seen_q;
      err_base  = pub_q ? 1'b0 : err_acc_q;
      work_d    = work_q;
      wdp_d     = wdp_q;
      seen_d    = seen_base;
      err_acc_d = err_base;
      if (capture) begin
         for (int unsigned i = 0; i < NDIG; i++) begin
            if (an[i]) begin
               work_d[4*i +: 4] = enc_bcd;
               wdp_d[i]         = seg[0];
            end
         end
         seen_d    = seen_base | an;
         err_acc_d = err_base | ~enc_valid;
      end
      pub_d         = capture && (seen_d == {NDIG{1'b1}});
      digits_d      = pub_q ? work_q    : digits_q;
      dp_flags_d    = pub_q ? wdp_q     : dp_flags_q;
      frame_err_d   = pub_q ? err_acc_q : frame_err_q;
      frame_valid_d = pub_q;
      if (capture) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_W'(TIMEOUT)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = tmo_q;
      end
      stale_d = (tmo_d == TMO_W'(TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_WAIT;
         scnt_q        <= '0;
         prev_q        <= '0;
         work_q        <= '0;
         wdp_q         <= '0;
         seen_q        <= '0;
         err_acc_q     <= 1'b0;
         pub_q         <= 1'b0;
         tmo_q         <= '0;
         digits_q      <= '0;
         dp_flags_q    <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         scnt_q        <= scnt_d;
         prev_q        <= prev_d;
         work_q        <= work_d;
         wdp_q         <= wdp_d;
         seen_q        <= seen_d;
         err_acc_q     <= err_acc_d;
         pub_q         <= pub_d;
         tmo_q         <= tmo_d;
         digits_q      <= digits_d;
         dp_flags_q    <= dp_flags_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         stale_q       <= stale_d;
      end
   end

   assign digits      = digits_q;
   assign dp_flags    = dp_flags_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign stale       = stale_q;

endmodule
